// File: rtl/i2c_pad_conditioner_pkg.sv
// rtl/i2c_pad_conditioner_pkg.sv - shared constants and width helper for the I2C pad conditioner
package i2c_pad_conditioner_pkg;

  localparam logic I2C_IDLE_LEVEL = 1'b1;
  localparam int   FILT_CNT_W     = 8;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int i2c_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/i2c_glitch_filter.sv
// rtl/i2c_glitch_filter.sv - per-line synchroniser plus consecutive-sample glitch filter
module i2c_glitch_filter
  import i2c_pad_conditioner_pkg::*;
#(
  parameter int FILTER_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync;
  logic [FILT_CNT_W-1:0]  cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {SYNC_STAGES{I2C_IDLE_LEVEL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pad};
    end
  end

  // Any reversal before the threshold restarts the count, so short glitches vanish.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= I2C_IDLE_LEVEL;
      cnt   <= '0;
    end else if (synced == level) begin
      cnt <= '0;
    end else if (cnt == FILT_CNT_W'(FILTER_CYCLES - 1)) begin
      level <= synced;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_pad_conditioner.sv
// rtl/i2c_pad_conditioner.sv - SCL/SDA conditioning: sync, deglitch, START/STOP, busy tracking
// Optional SCL-stuck-low timeout enabled by defining I2C_BUS_TIMEOUT_EN.
module i2c_pad_conditioner
  import i2c_pad_conditioner_pkg::*;
#(
  parameter int FILTER_CYCLES  = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic scl_pad_i,
  input  logic sda_pad_i,
  output logic scl_o,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic busy_o,
  output logic timeout_o,
  input  logic timeout_clr_i
);

  logic scl_f;
  logic sda_f;
  logic scl_prev;
  logic sda_prev;
  logic start_cond;
  logic stop_cond;
  logic to_hit;

  i2c_glitch_filter #(
    .FILTER_CYCLES(FILTER_CYCLES),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_scl_filter (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .pad  (scl_pad_i),
    .level(scl_f)
  );

  i2c_glitch_filter #(
    .FILTER_CYCLES(FILTER_CYCLES),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_sda_filter (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .pad  (sda_pad_i),
    .level(sda_f)
  );

  assign scl_o = scl_f;
  assign sda_o = sda_f;

  // SCL must be stably high across the SDA transition; a simultaneous SCL change disqualifies it.
  assign start_cond = scl_prev & scl_f & sda_prev & ~sda_f;
  assign stop_cond  = scl_prev & scl_f & ~sda_prev & sda_f;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      scl_prev   <= I2C_IDLE_LEVEL;
      sda_prev   <= I2C_IDLE_LEVEL;
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      scl_prev   <= scl_f;
      sda_prev   <= sda_f;
      scl_rise_o <= scl_f & ~scl_prev;
      scl_fall_o <= ~scl_f & scl_prev;
      start_o    <= start_cond;
      stop_o     <= stop_cond;
      if (to_hit) begin
        busy_o <= 1'b0;
      end else if (start_cond) begin
        busy_o <= 1'b1;
      end else if (stop_cond) begin
        busy_o <= 1'b0;
      end
    end
  end

`ifdef I2C_BUS_TIMEOUT_EN
  localparam int TO_W = i2c_clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;

  assign to_hit = ~scl_f && (to_cnt == TO_W'(TIMEOUT_CYCLES));

  // Counter saturates at the limit; setting the flag takes priority over a clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      to_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (scl_f) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (to_hit) begin
        timeout_o <= 1'b1;
      end else if (timeout_clr_i) begin
        timeout_o <= 1'b0;
      end
    end
  end
`else
  logic unused_timeout;

  assign to_hit         = 1'b0;
  assign timeout_o      = 1'b0;
  assign unused_timeout = &{1'b0, timeout_clr_i, TIMEOUT_CYCLES[0]};
`endif

endmodule

// File: tb/tb_i2c_pad_conditioner.sv
// tb/tb_i2c_pad_conditioner.sv - directed bench: table of bus states plus glitch, reset and timeout sequences
module tb_i2c_pad_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_pad = 1'b1;
  logic sda_pad = 1'b1;
  logic timeout_clr = 1'b0;
  logic scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, busy_o, timeout_o;

  int n_vec = 0;
  int n_bad = 0;
  int t_start = 0, t_stop = 0, t_rise = 0, t_fall = 0;

  always #5 clk = ~clk;

  i2c_pad_conditioner #(
    .FILTER_CYCLES (4),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .scl_pad_i    (scl_pad),
    .sda_pad_i    (sda_pad),
    .scl_o        (scl_o),
    .sda_o        (sda_o),
    .scl_rise_o   (scl_rise_o),
    .scl_fall_o   (scl_fall_o),
    .start_o      (start_o),
    .stop_o       (stop_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o),
    .timeout_clr_i(timeout_clr)
  );

  always @(negedge clk) begin
    if (start_o) t_start++;
    if (stop_o) t_stop++;
    if (scl_rise_o) t_rise++;
    if (scl_fall_o) t_fall++;
  end

  typedef struct {
    logic scl;
    logic sda;
    logic e_scl;
    logic e_sda;
    logic e_busy;
    int   e_start;
    int   e_stop;
    int   e_rise;
    int   e_fall;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
  endtask

  task automatic check_pulses(input string tag, input int s0, input int p0, input int r0,
                              input int f0, input int es, input int ep, input int er, input int ef);
    check({tag, " start_cnt"}, t_start - s0, es);
    check({tag, " stop_cnt"}, t_stop - p0, ep);
    check({tag, " rise_cnt"}, t_rise - r0, er);
    check({tag, " fall_cnt"}, t_fall - f0, ef);
  endtask

  initial begin
    int s0, p0, r0, f0;
    int first;
    logic seen_low;

    //          scl   sda   e_scl e_sda busy  st sp ri fa
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 1, 0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 0, 0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 0, 1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1, 0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 0, 0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 0, 0};

    // Reset state, then 100 quiet cycles on idle pads.
    rst = 1'b1;
    cycles(2);
    check("reset scl_o", scl_o, 1);
    check("reset sda_o", sda_o, 1);
    check("reset busy_o", busy_o, 0);
    check("reset timeout_o", timeout_o, 0);
    check("reset start_o", start_o, 0);
    rst = 1'b0;
    s0 = t_start; p0 = t_stop; r0 = t_rise; f0 = t_fall;
    cycles(100);
    check_pulses("idle", s0, p0, r0, f0, 0, 0, 0, 0);
    check("idle busy_o", busy_o, 0);

    // Three-clock SDA glitch must be rejected entirely.
    seen_low = 1'b0;
    sda_pad = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cycles(1);
      if (k == 3) sda_pad = 1'b1;
      if (sda_o == 1'b0) seen_low = 1'b1;
    end
    check("glitch3 sda_low_seen", seen_low, 0);

    // Four-clock pulse passes; sda_o falls six clocks after the pad edge.
    first = -1;
    sda_pad = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cycles(1);
      if (k == 4) sda_pad = 1'b1;
      if (sda_o == 1'b0 && first < 0) first = k;
    end
    check("glitch4 latency", first, 6);
    cycles(20);

    // Table of bus states, each held long enough to settle.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      s0 = t_start; p0 = t_stop; r0 = t_rise; f0 = t_fall;
      scl_pad = tbl[i].scl;
      sda_pad = tbl[i].sda;
      cycles(12);
      check($sformatf("row%0d scl_o", i), scl_o, tbl[i].e_scl);
      check($sformatf("row%0d sda_o", i), sda_o, tbl[i].e_sda);
      check($sformatf("row%0d busy_o", i), busy_o, tbl[i].e_busy);
      check_pulses($sformatf("row%0d", i), s0, p0, r0, f0,
                   tbl[i].e_start, tbl[i].e_stop, tbl[i].e_rise, tbl[i].e_fall);
    end

    // Reset while busy with SDA low: no pulses afterwards, busy cleared.
    scl_pad = 1'b1; sda_pad = 1'b0;
    cycles(12);
    check("pre_reset busy_o", busy_o, 1);
    check("pre_reset sda_o", sda_o, 0);
    scl_pad = 1'b1; sda_pad = 1'b1;
    rst = 1'b1;
    cycles(1);
    check("midreset sda_o", sda_o, 1);
    check("midreset busy_o", busy_o, 0);
    rst = 1'b0;
    s0 = t_start; p0 = t_stop; r0 = t_rise; f0 = t_fall;
    cycles(20);
    check_pulses("post_reset", s0, p0, r0, f0, 0, 0, 0, 0);
    check("post_reset busy_o", busy_o, 0);

`ifdef I2C_BUS_TIMEOUT_EN
    // Start a transfer, then hold SCL low past the limit.
    sda_pad = 1'b0;
    cycles(12);
    check("to busy_before", busy_o, 1);
    scl_pad = 1'b0;
    cycles(90);
    check("to not_yet", timeout_o, 0);
    cycles(30);
    check("to set", timeout_o, 1);
    check("to busy_forced", busy_o, 0);
    scl_pad = 1'b1;
    cycles(12);
    check("to sticky", timeout_o, 1);
    timeout_clr = 1'b1;
    cycles(1);
    timeout_clr = 1'b0;
    check("to cleared", timeout_o, 0);
    // Reset mid-count restarts the counter from zero.
    scl_pad = 1'b0;
    cycles(60);
    do_reset();
    check("to reset flag", timeout_o, 0);
    cycles(80);
    check("to restarted", timeout_o, 0);
    cycles(40);
    check("to after_restart", timeout_o, 1);
    scl_pad = 1'b1; sda_pad = 1'b1;
    cycles(12);
`else
    scl_pad = 1'b0;
    timeout_clr = 1'b1;
    cycles(20);
    timeout_clr = 1'b0;
    check("to disabled", timeout_o, 0);
    scl_pad = 1'b1;
    cycles(12);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
